// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for the split instr/data ports of the pipelined datapath.
// Serializes both requests onto pmem_* and releases both ports with one joint response.
module mem_port_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1,
    parameter bit ALIGN_ADDR    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    output logic [31:0] instr_mem_rdata,
    output logic        instr_mem_resp,

    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  data_mbe,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_D,
        SERVE_I,
        RELEASE
    } state_t;

    state_t state;
    state_t next_state;

    logic        act_i;
    logic        act_d;
    logic        rec_i;
    logic        rec_d;
    logic        done_i;
    logic        done_d;
    logic        d_write;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mbe;
    logic [31:0] buf_i;
    logic [31:0] buf_d;
    logic [31:0] raw_addr;

    assign act_i = instr_read;
    assign act_d = data_read | data_write;

    // Request fields are captured only in IDLE, so ports raised mid-service wait for the next round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rec_i   <= 1'b0;
            rec_d   <= 1'b0;
            done_i  <= 1'b0;
            done_d  <= 1'b0;
            d_write <= 1'b0;
            i_addr  <= '0;
            d_addr  <= '0;
            d_wdata <= '0;
            d_mbe   <= '0;
            buf_i   <= '0;
            buf_d   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (act_i || act_d) begin
                        rec_i <= act_i;
                        rec_d <= act_d;
                        buf_i <= '0;
                        buf_d <= '0;
                        if (act_i) begin
                            i_addr <= instr_mem_address;
                        end
                        if (act_d) begin
                            d_addr  <= data_mem_address;
                            d_wdata <= data_mem_wdata;
                            d_mbe   <= data_mbe;
                            d_write <= data_write;
                        end
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        buf_d  <= d_write ? 32'h0 : pmem_rdata;
                        done_d <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        buf_i  <= pmem_rdata;
                        done_i <= 1'b1;
                    end
                end
                RELEASE: begin
                    done_i <= 1'b0;
                    done_d <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (act_i || act_d) begin
                    if (DATA_PRIORITY) begin
                        next_state = act_d ? SERVE_D : SERVE_I;
                    end else begin
                        next_state = act_i ? SERVE_I : SERVE_D;
                    end
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    next_state = (rec_i && !done_i) ? SERVE_I : RELEASE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    next_state = (rec_d && !done_d) ? SERVE_D : RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All outputs decode from the registered state, so a reset forces them to 0 on the next cycle.
    always_comb begin
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_wdata      = '0;
        pmem_mbe        = '0;
        raw_addr        = '0;
        instr_mem_resp  = 1'b0;
        data_mem_resp   = 1'b0;
        instr_mem_rdata = '0;
        data_mem_rdata  = '0;
        case (state)
            SERVE_D: begin
                raw_addr   = d_addr;
                pmem_read  = ~d_write;
                pmem_write = d_write;
                pmem_wdata = d_write ? d_wdata : 32'h0;
                pmem_mbe   = d_write ? d_mbe : 4'hF;
            end
            SERVE_I: begin
                raw_addr  = i_addr;
                pmem_read = 1'b1;
                pmem_mbe  = 4'hF;
            end
            RELEASE: begin
                instr_mem_resp  = rec_i;
                data_mem_resp   = rec_d;
                instr_mem_rdata = buf_i;
                data_mem_rdata  = buf_d;
            end
            default: ;
        endcase
        pmem_address = ALIGN_ADDR ? {raw_addr[31:2], 2'b00} : raw_addr;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default instance plus one with instr priority and no alignment,
// each backed by a small fixed-latency memory responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_read = 1'b0;
    logic [31:0] instr_mem_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_mem_address = '0;
    logic [31:0] data_mem_wdata = '0;
    logic [3:0]  data_mbe = '0;

    logic [31:0] instr_mem_rdata_a, data_mem_rdata_a, pmem_address_a, pmem_wdata_a;
    logic        instr_mem_resp_a, data_mem_resp_a, pmem_read_a, pmem_write_a;
    logic [3:0]  pmem_mbe_a;
    logic [31:0] pmem_rdata_a = '0;
    logic        pmem_resp_a = 1'b0;

    logic [31:0] instr_mem_rdata_b, data_mem_rdata_b, pmem_address_b, pmem_wdata_b;
    logic        instr_mem_resp_b, data_mem_resp_b, pmem_read_b, pmem_write_b;
    logic [3:0]  pmem_mbe_b;
    logic [31:0] pmem_rdata_b = '0;
    logic        pmem_resp_b = 1'b0;

    int lat = 1;
    int cnt_a = 0;
    int cnt_b = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_PRIORITY(1'b1), .ALIGN_ADDR(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_mem_address(instr_mem_address),
        .instr_mem_rdata(instr_mem_rdata_a), .instr_mem_resp(instr_mem_resp_a),
        .data_read(data_read), .data_write(data_write), .data_mem_address(data_mem_address),
        .data_mem_wdata(data_mem_wdata), .data_mbe(data_mbe),
        .data_mem_rdata(data_mem_rdata_a), .data_mem_resp(data_mem_resp_a),
        .pmem_read(pmem_read_a), .pmem_write(pmem_write_a), .pmem_address(pmem_address_a),
        .pmem_wdata(pmem_wdata_a), .pmem_mbe(pmem_mbe_a),
        .pmem_rdata(pmem_rdata_a), .pmem_resp(pmem_resp_a)
    );

    mem_port_arbiter #(.DATA_PRIORITY(1'b0), .ALIGN_ADDR(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_mem_address(instr_mem_address),
        .instr_mem_rdata(instr_mem_rdata_b), .instr_mem_resp(instr_mem_resp_b),
        .data_read(data_read), .data_write(data_write), .data_mem_address(data_mem_address),
        .data_mem_wdata(data_mem_wdata), .data_mbe(data_mbe),
        .data_mem_rdata(data_mem_rdata_b), .data_mem_resp(data_mem_resp_b),
        .pmem_read(pmem_read_b), .pmem_write(pmem_write_b), .pmem_address(pmem_address_b),
        .pmem_wdata(pmem_wdata_b), .pmem_mbe(pmem_mbe_b),
        .pmem_rdata(pmem_rdata_b), .pmem_resp(pmem_resp_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == 32'h60) ? 32'h0000_0013 : {addr[15:0], 16'hBEEF};
    endfunction

    // Responders count request cycles and answer on the lat-th one.
    always @(negedge clk) begin
        pmem_resp_a = 1'b0;
        if (pmem_read_a || pmem_write_a) begin
            cnt_a = cnt_a + 1;
            if (cnt_a >= lat) begin
                pmem_resp_a  = 1'b1;
                pmem_rdata_a = mem_word(pmem_address_a);
                cnt_a = 0;
            end
        end else begin
            cnt_a = 0;
        end
    end

    always @(negedge clk) begin
        pmem_resp_b = 1'b0;
        if (pmem_read_b || pmem_write_b) begin
            cnt_b = cnt_b + 1;
            if (cnt_b >= lat) begin
                pmem_resp_b  = 1'b1;
                pmem_rdata_b = mem_word(pmem_address_b);
                cnt_b = 0;
            end
        end else begin
            cnt_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_pmem_read", {31'h0, pmem_read_a}, 32'h0);
        checkOutput("rst_pmem_write", {31'h0, pmem_write_a}, 32'h0);
        checkOutput("rst_pmem_addr", pmem_address_a, 32'h0);
        checkOutput("rst_pmem_mbe", {28'h0, pmem_mbe_a}, 32'h0);
        checkOutput("rst_i_resp", {31'h0, instr_mem_resp_a}, 32'h0);
        checkOutput("rst_d_resp", {31'h0, data_mem_resp_a}, 32'h0);
        checkOutput("rst_b_pmem_read", {31'h0, pmem_read_b}, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] fetch only, L=1");
        lat = 1;
        instr_read = 1'b1;
        instr_mem_address = 32'h60;
        tick();
        checkOutput("t1_pmem_read", {31'h0, pmem_read_a}, 32'h1);
        checkOutput("t1_pmem_addr", pmem_address_a, 32'h60);
        checkOutput("t1_pmem_mbe", {28'h0, pmem_mbe_a}, 32'hF);
        checkOutput("t1_i_resp_early", {31'h0, instr_mem_resp_a}, 32'h0);
        tick();
        checkOutput("t1_i_resp", {31'h0, instr_mem_resp_a}, 32'h1);
        checkOutput("t1_i_rdata", instr_mem_rdata_a, 32'h13);
        checkOutput("t1_d_resp", {31'h0, data_mem_resp_a}, 32'h0);
        checkOutput("t1_pmem_read_drop", {31'h0, pmem_read_a}, 32'h0);
        instr_read = 1'b0;
        tick();
        checkOutput("t1_i_resp_gone", {31'h0, instr_mem_resp_a}, 32'h0);
        checkOutput("t1_i_rdata_zero", instr_mem_rdata_a, 32'h0);

        $display("[TB] load + fetch, L=2, both priorities");
        lat = 2;
        data_read = 1'b1;
        data_mem_address = 32'h1004;
        instr_read = 1'b1;
        instr_mem_address = 32'h64;
        tick();
        checkOutput("t2_a_addr_t1", pmem_address_a, 32'h1004);
        checkOutput("t6_b_addr_t1", pmem_address_b, 32'h64);
        tick();
        checkOutput("t2_a_addr_t2", pmem_address_a, 32'h1004);
        tick();
        checkOutput("t2_a_addr_t3", pmem_address_a, 32'h64);
        checkOutput("t2_a_read_t3", {31'h0, pmem_read_a}, 32'h1);
        checkOutput("t6_b_addr_t3", pmem_address_b, 32'h1004);
        tick();
        checkOutput("t2_a_addr_t4", pmem_address_a, 32'h64);
        checkOutput("t2_a_i_resp_t4", {31'h0, instr_mem_resp_a}, 32'h0);
        tick();
        checkOutput("t2_a_i_resp", {31'h0, instr_mem_resp_a}, 32'h1);
        checkOutput("t2_a_d_resp", {31'h0, data_mem_resp_a}, 32'h1);
        checkOutput("t2_a_i_rdata", instr_mem_rdata_a, 32'h0064BEEF);
        checkOutput("t2_a_d_rdata", data_mem_rdata_a, 32'h1004BEEF);
        checkOutput("t6_b_i_resp", {31'h0, instr_mem_resp_b}, 32'h1);
        checkOutput("t6_b_d_resp", {31'h0, data_mem_resp_b}, 32'h1);
        checkOutput("t6_b_i_rdata", instr_mem_rdata_b, 32'h0064BEEF);
        checkOutput("t6_b_d_rdata", data_mem_rdata_b, 32'h1004BEEF);
        data_read = 1'b0;
        instr_read = 1'b0;
        tick();

        $display("[TB] store, L=3");
        lat = 3;
        data_write = 1'b1;
        data_mem_address = 32'h2000;
        data_mem_wdata = 32'h0000AB00;
        data_mbe = 4'b0010;
        tick();
        checkOutput("t3_write_t1", {31'h0, pmem_write_a}, 32'h1);
        checkOutput("t3_read_t1", {31'h0, pmem_read_a}, 32'h0);
        checkOutput("t3_wdata", pmem_wdata_a, 32'h0000AB00);
        checkOutput("t3_mbe", {28'h0, pmem_mbe_a}, 32'h2);
        checkOutput("t3_addr", pmem_address_a, 32'h2000);
        tick();
        tick();
        checkOutput("t3_write_t3", {31'h0, pmem_write_a}, 32'h1);
        tick();
        checkOutput("t3_d_resp", {31'h0, data_mem_resp_a}, 32'h1);
        checkOutput("t3_d_rdata", data_mem_rdata_a, 32'h0);
        checkOutput("t3_write_drop", {31'h0, pmem_write_a}, 32'h0);
        checkOutput("t3_i_resp", {31'h0, instr_mem_resp_a}, 32'h0);
        data_write = 1'b0;
        data_mbe = 4'h0;
        data_mem_wdata = 32'h0;
        tick();

        $display("[TB] reset during a 4-cycle load");
        lat = 4;
        data_read = 1'b1;
        data_mem_address = 32'h3000;
        tick();
        checkOutput("t4_read_t1", {31'h0, pmem_read_a}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 1;
        checkOutput("t4_read_after_rst", {31'h0, pmem_read_a}, 32'h0);
        checkOutput("t4_addr_after_rst", pmem_address_a, 32'h0);
        checkOutput("t4_d_resp_after_rst", {31'h0, data_mem_resp_a}, 32'h0);
        tick();
        checkOutput("t4_read_restart", {31'h0, pmem_read_a}, 32'h1);
        checkOutput("t4_d_resp_early", {31'h0, data_mem_resp_a}, 32'h0);
        tick();
        checkOutput("t4_d_resp", {31'h0, data_mem_resp_a}, 32'h1);
        checkOutput("t4_d_rdata", data_mem_rdata_a, 32'h3000BEEF);
        data_read = 1'b0;
        tick();

        $display("[TB] unaligned fetch");
        lat = 1;
        instr_read = 1'b1;
        instr_mem_address = 32'h66;
        tick();
        checkOutput("t5_a_aligned", pmem_address_a, 32'h64);
        checkOutput("t5_b_unaligned", pmem_address_b, 32'h66);
        tick();
        checkOutput("t5_a_rdata", instr_mem_rdata_a, 32'h0064BEEF);
        checkOutput("t5_b_rdata", instr_mem_rdata_b, 32'h0066BEEF);
        instr_read = 1'b0;
        tick();

        $display("[TB] fetch raised mid-service waits for next round");
        lat = 2;
        data_read = 1'b1;
        data_mem_address = 32'h1008;
        tick();
        instr_read = 1'b1;
        instr_mem_address = 32'h68;
        tick();
        tick();
        checkOutput("t7_d_resp", {31'h0, data_mem_resp_a}, 32'h1);
        checkOutput("t7_i_not_added", {31'h0, instr_mem_resp_a}, 32'h0);
        data_read = 1'b0;
        tick();
        checkOutput("t7_idle_between", {31'h0, pmem_read_a}, 32'h0);
        tick();
        checkOutput("t7_i_addr", pmem_address_a, 32'h68);
        tick();
        tick();
        checkOutput("t7_i_resp", {31'h0, instr_mem_resp_a}, 32'h1);
        checkOutput("t7_i_rdata", instr_mem_rdata_a, 32'h0068BEEF);
        instr_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
